// File: rtl/windowing_pkg.sv
// Shared defaults, FSM state type and width helper for the windowing_frame block.
package windowing_pkg;

  localparam int unsigned DATA_W_DEF    = 17;
  localparam int unsigned COEF_W_DEF    = 4;
  localparam int unsigned FRAME_LEN_DEF = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Signed sample times unsigned coefficient needs exactly DATA_W+COEF_W bits.
  function automatic int unsigned out_w(input int unsigned data_w, input int unsigned coef_w);
    return data_w + coef_w;
  endfunction

endpackage

// File: rtl/windowing_coef_ram.sv
// Run-time loadable coefficient table: one synchronous write port, one asynchronous read port.
module windowing_coef_ram #(
  parameter int unsigned COEF_W    = 4,
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [COEF_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [COEF_W-1:0] rdata
);

  logic [COEF_W-1:0] mem [FRAME_LEN];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/windowing_frame.sv
// Streaming frame windowing unit: 2-stage valid/ready pipeline multiplying each signed
// sample by the coefficient at its frame position; table writable only between frames.
module windowing_frame
  import windowing_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned COEF_W    = COEF_W_DEF,
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned IDX_W     = $clog2(FRAME_LEN),
  parameter int unsigned OUT_W     = out_w(DATA_W, COEF_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  input  logic              coef_we,
  input  logic [IDX_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              coef_err
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               stall;
  logic               accept;
  logic               idx_last;
  logic               coef_wr_ok;
  logic [COEF_W-1:0]  coef_rd;

  logic               s1_valid;
  logic [DATA_W-1:0]  s1_data;
  logic [COEF_W:0]    s1_coef;
  logic               s1_last;

  logic [OUT_W-1:0]   data_ext;
  logic [OUT_W-1:0]   coef_ext;
  logic [OUT_W-1:0]   product;

  // Whole pipe freezes on a stalled output; there is no skid buffer.
  assign stall    = out_valid && !out_ready;
  assign in_ready = enable && !stall;
  assign accept   = in_valid && in_ready;
  assign idx_last = (idx_q == IDX_W'(FRAME_LEN - 1));

  windowing_coef_ram #(
    .COEF_W    (COEF_W),
    .FRAME_LEN (FRAME_LEN),
    .IDX_W     (IDX_W)
  ) u_coef_ram (
    .clk   (clk),
    .we    (coef_wr_ok && !rst),
    .waddr (coef_addr),
    .wdata (coef_wdata),
    .raddr (idx_q),
    .rdata (coef_rd)
  );

  always_comb begin
    state_d    = state_q;
    coef_wr_ok = coef_we && (state_q == IDLE) && !accept;
    unique case (state_q)
      IDLE: if (accept)             state_d = RUN;
      RUN:  if (accept && idx_last) state_d = IDLE;
    endcase
  end

  // Both operands widened to OUT_W so the low OUT_W product bits are exact.
  assign data_ext = {{COEF_W{s1_data[DATA_W-1]}}, s1_data};
  assign coef_ext = {{(DATA_W-1){1'b0}}, s1_coef};
  assign product  = data_ext * coef_ext;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_coef   <= '0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (!stall) begin
      state_q   <= state_d;
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= product;
        out_last <= s1_last;
      end
      s1_valid <= accept;
      if (accept) begin
        s1_data <= in_data;
        s1_coef <= {1'b0, coef_rd};
        s1_last <= idx_last;
        idx_q   <= idx_last ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coef_err <= 1'b0;
    end else begin
      coef_err <= coef_we && !coef_wr_ok;
    end
  end

endmodule

// File: tb/tb_windowing_frame.sv
// Directed and randomized checks of windowing_frame (FRAME_LEN=4) against a frame-position reference model.
module tb_windowing_frame;

  localparam int DW = 17;
  localparam int CW = 4;
  localparam int FL = 4;
  localparam int IW = 2;
  localparam int OW = 21;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          coef_we;
  logic [IW-1:0] coef_addr;
  logic [CW-1:0] coef_wdata;
  logic          coef_err;

  windowing_frame #(
    .DATA_W    (DW),
    .COEF_W    (CW),
    .FRAME_LEN (FL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_err   (coef_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: table contents, frame position and the two in-flight slots.
  int m_coef [FL];
  int m_pos;
  bit m_s1v, m_ov, m_s1l, m_ol, m_err;
  int m_s1d, m_s1c, m_od;
  bit last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_s1v = 0; m_ov = 0; m_s1l = 0; m_ol = 0;
    m_s1d = 0; m_s1c = 0; m_od = 0; m_pos = 0;
  endtask

  task automatic cycle();
    bit stall, exp_rdy, acc, wr_ok;
    logic [OW-1:0] exp_d;
    #1;
    stall   = m_ov && !out_ready;
    exp_rdy = enable && !stall;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("coef_err", 64'(coef_err), 64'(m_err));
    if (m_ov) begin
      exp_d = OW'(m_od);
      chk("out_data", 64'(out_data), 64'(exp_d));
      chk("out_last", 64'(out_last), 64'(m_ol));
    end
    acc = in_valid && exp_rdy;
    last_acc = acc;
    if (rst) begin
      model_clear();
      m_err = 0;
    end else begin
      wr_ok = coef_we && (m_pos == 0) && !acc;
      m_err = coef_we && !wr_ok;
      if (wr_ok) m_coef[coef_addr] = int'(coef_wdata);
      if (!enable) begin
        model_clear();
      end else if (!stall) begin
        m_ov = m_s1v;
        if (m_s1v) begin
          m_od = m_s1d * m_s1c;
          m_ol = m_s1l;
        end
        m_s1v = acc;
        if (acc) begin
          m_s1d = int'($signed(in_data));
          m_s1c = m_coef[m_pos];
          m_s1l = (m_pos == FL - 1);
          m_pos = (m_pos + 1) % FL;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    coef_we  = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Presents one sample until the model says it was accepted (bounded).
  task automatic offer(input int d);
    int tries;
    tries = 0;
    in_valid = 1;
    in_data  = DW'(d);
    do begin
      cycle();
      tries++;
    end while (!last_acc && tries < 40);
    if (!last_acc) chk("accept_timeout", 64'(tries), 64'(0));
    in_valid = 0;
  endtask

  task automatic write_coef(input int a, input int v);
    coef_we    = 1;
    coef_addr  = IW'(a);
    coef_wdata = CW'(v);
    cycle();
    coef_we    = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_data"}, 64'(out_data), 64'(0));
    chk({tag, "_out_last"}, 64'(out_last), 64'(0));
    chk({tag, "_coef_err"}, 64'(coef_err), 64'(0));
  endtask

  initial begin
    rst = 1; enable = 1; in_valid = 0; in_data = '0; out_ready = 1;
    coef_we = 0; coef_addr = '0; coef_wdata = '0;
    for (int i = 0; i < FL; i++) m_coef[i] = 0;
    model_clear();
    m_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;

    // Load {1,5,15,0} and stream the reference frame.
    write_coef(0, 1); write_coef(1, 5); write_coef(2, 15); write_coef(3, 0);
    offer(1000); offer(-2000); offer(-65536); offer(777);
    idle(3);

    // Mid-frame output stall with input kept pending.
    offer(300); offer(-301);
    out_ready = 1;
    in_valid = 1; in_data = DW'(302);
    cycle();
    out_ready = 0;
    for (int i = 0; i < 5; i++) cycle();
    out_ready = 1;
    in_valid = 0;
    offer(303);
    idle(3);

    // Coefficient write while a frame is running is rejected.
    offer(11); offer(12);
    write_coef(1, 9);
    offer(13); offer(14);
    offer(21); offer(22); offer(23); offer(24);
    idle(3);

    // Flush at index 2, then a fresh frame from coef[0].
    offer(-5); offer(6);
    enable = 0;
    idle(2);
    enable = 1;
    offer(100); offer(200); offer(300); offer(400);
    idle(3);

    // Reset mid-frame: outputs clear, table retained.
    offer(7); offer(8);
    in_valid = 1; in_data = DW'(9);
    rst = 1;
    cycle();
    rst = 0;
    in_valid = 0;
    check_reset_outputs("midreset");
    offer(1000); offer(-2000); offer(-65536); offer(777);
    idle(3);

    // Back-to-back frames with continuous valid.
    for (int i = 0; i < 8; i++) offer(i * 1111 - 4000);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = ($urandom_range(0, 9) == 0) ? DW'(-65536) : DW'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      coef_we    = ($urandom_range(0, 7) == 0);
      coef_addr  = IW'($urandom);
      coef_wdata = CW'($urandom);
      enable     = ($urandom_range(0, 29) != 0);
      rst        = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 0; enable = 1; out_ready = 1;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
